// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: predictor lookup, imem request/response, ID redirect and decode handoff.
// master = fetch unit side, slave = surrounding pipeline/memory side.
interface fetch_unit_if;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_d_valid;
  logic        inst_d_ready;
  logic [31:0] inst_d;
  logic [31:0] pc_d;
  logic        pred_taken_d;
  logic [31:0] pred_target_d;

  modport master (
    output pc_f, imem_req_valid, imem_req_addr,
           inst_d_valid, inst_d, pc_d, pred_taken_d, pred_target_d,
    input  pred_taken, pred_target, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_d_ready
  );

  modport slave (
    input  pc_f, imem_req_valid, imem_req_addr,
           inst_d_valid, inst_d, pc_d, pred_taken_d, pred_target_d,
    output pred_taken, pred_target, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_d_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// IF-stage PC generator with an in-order fetch queue feeding decode.
// Define FETCH_PERF_CNT_EN to add the perf_redirects / perf_stall_cycles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles,
`endif
  fetch_unit_if.master bus
);
  localparam int PTR_W  = $clog2(FQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = 8;

  logic [31:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [31:0]       ent_pc_q   [FQ_DEPTH];
  logic [31:0]       ent_pc_d   [FQ_DEPTH];
  logic [31:0]       ent_tgt_q  [FQ_DEPTH];
  logic [31:0]       ent_tgt_d  [FQ_DEPTH];
  logic [31:0]       ent_inst_q [FQ_DEPTH];
  logic [31:0]       ent_inst_d [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] ent_pt_q, ent_pt_d;
  logic [FQ_DEPTH-1:0] ent_filled_q, ent_filled_d;

  logic full, req_fire, pop_fire, rsp_fill, rsp_drop;

  assign full     = (alloc_cnt_q == CNT_W'(FQ_DEPTH));
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pop_fire = bus.inst_d_valid && bus.inst_d_ready;
  // Responses still owed to flushed requests are swallowed before any new entry fills.
  assign rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_fill = bus.imem_rsp_valid && (drop_cnt_q == '0);

  assign bus.pc_f           = pc_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.imem_req_valid = !reset && !full && !bus.redirect_valid;
  assign bus.inst_d_valid   = ent_filled_q[head_ptr_q] && !bus.redirect_valid;
  assign bus.inst_d         = ent_inst_q[head_ptr_q];
  assign bus.pc_d           = ent_pc_q[head_ptr_q];
  assign bus.pred_taken_d   = ent_pt_q[head_ptr_q];
  assign bus.pred_target_d  = ent_tgt_q[head_ptr_q];

  always_comb begin
    pc_d         = pc_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    alloc_cnt_d  = alloc_cnt_q;
    pend_cnt_d   = pend_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ent_pc_d     = ent_pc_q;
    ent_tgt_d    = ent_tgt_q;
    ent_inst_d   = ent_inst_q;
    ent_pt_d     = ent_pt_q;
    ent_filled_d = ent_filled_q;

    if (bus.redirect_valid) begin
      pc_d         = bus.redirect_pc;
      alloc_ptr_d  = '0;
      fill_ptr_d   = '0;
      head_ptr_d   = '0;
      alloc_cnt_d  = '0;
      pend_cnt_d   = '0;
      ent_filled_d = '0;
      // A same-cycle response retires either one drop credit or one pending entry.
      drop_cnt_d   = drop_cnt_q + DROP_W'(pend_cnt_q) - DROP_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d                  = bus.pred_taken ? bus.pred_target : pc_q + 32'd4;
        ent_pc_d[alloc_ptr_q]  = pc_q;
        ent_pt_d[alloc_ptr_q]  = bus.pred_taken;
        ent_tgt_d[alloc_ptr_q] = bus.pred_target;
        alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
      end
      if (rsp_fill) begin
        ent_inst_d[fill_ptr_q]   = bus.imem_rsp_data;
        ent_filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d               = fill_ptr_q + PTR_W'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
      if (pop_fire) begin
        ent_filled_d[head_ptr_q] = 1'b0;
        head_ptr_d               = head_ptr_q + PTR_W'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CNT_W'(req_fire) - CNT_W'(pop_fire);
      pend_cnt_d  = pend_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      alloc_cnt_q  <= '0;
      pend_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      ent_pt_q     <= '0;
      ent_filled_q <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_tgt_q[i]  <= '0;
        ent_inst_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      alloc_cnt_q  <= alloc_cnt_d;
      pend_cnt_q   <= pend_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ent_pt_q     <= ent_pt_d;
      ent_filled_q <= ent_filled_d;
      ent_pc_q     <= ent_pc_d;
      ent_tgt_q    <= ent_tgt_d;
      ent_inst_q   <= ent_inst_d;
    end
  end

  // imem must never answer a request that was never issued.
  assert property (@(posedge clk) disable iff (reset)
    bus.imem_rsp_valid |-> ((drop_cnt_q != '0) || (pend_cnt_q != '0)))
    else $error("fetch_unit: imem response with no outstanding request");

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q + 32'(bus.redirect_valid);
    perf_stall_d     = perf_stall_q +
                       32'((bus.imem_req_valid && !bus.imem_req_ready) || full);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_redirects_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_stall_q     <= perf_stall_d;
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_stall_cycles = perf_stall_q;
`endif
endmodule
